// File: rtl/ifu_prefetch_buf.sv
// Sequential instruction prefetcher between the IFU and the ITCM ICB port.
// Optional perf counters are enabled by defining IFU_PFB_PERF_EN.
module ifu_prefetch_buf #(
  parameter int PC_W     = 32,
  parameter int ADDR_W   = 16,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_OUTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PC_W-1:0]              pc_rtvec,
  output logic                         itcm_cmd_valid,
  input  logic                         itcm_cmd_ready,
  output logic [ADDR_W-1:0]            itcm_cmd_addr,
  input  logic                         itcm_rsp_valid,
  output logic                         itcm_rsp_ready,
  input  logic [DW-1:0]                itcm_rsp_rdata,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [DW-1:0]                o_instr,
  output logic [PC_W-1:0]              o_pc,
  input  logic                         flush_req,
  input  logic [PC_W-1:0]              flush_pc,
  output logic                         flush_ack,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
`ifdef IFU_PFB_PERF_EN
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_drop_cnt,
`endif
  output logic                         o_dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTS + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(DW / 8);

  // Handshake semantics: a transfer happens on a cycle where valid & ready are
  // both high; valid never depends on ready. Responses always accepted.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_rsp_pc;
  logic [CNT_W-1:0]   r_count;
  logic [OUT_W-1:0]   r_outs;
  logic [OUT_W-1:0]   r_drop;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [DW-1:0]      r_mem_instr [DEPTH];
  logic [PC_W-1:0]    r_mem_pc    [DEPTH];

  logic               w_run;
  logic               w_cmd_valid;
  logic               w_cmd_hs;
  logic               w_push;
  logic               w_drop_rsp;
  logic               w_pop;
  logic               w_o_valid;
  logic [CNT_W:0]     w_inflight;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus issue/accept decisions
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_inflight  = {1'b0, r_count} + (CNT_W+1)'(r_outs);
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_run       = 1'b1;
      default: w_state_nxt = ST_BOOT;
    endcase
    // Counting buffered plus in-flight entries keeps the FIFO from overflowing.
    w_cmd_valid = w_run & ~flush_req
                & (r_outs < OUT_W'(MAX_OUTS))
                & (w_inflight < (CNT_W+1)'(DEPTH));
    w_cmd_hs    = w_cmd_valid & itcm_cmd_ready;
    w_drop_rsp  = itcm_rsp_valid & (flush_req | (r_drop != '0));
    w_push      = itcm_rsp_valid & ~flush_req & (r_drop == '0);
    w_o_valid   = (r_count != '0) & ~flush_req;
    w_pop       = w_o_valid & o_ready;
  end

  // Fetch/response PCs and in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= pc_rtvec;
      r_rsp_pc   <= pc_rtvec;
      r_outs     <= '0;
      r_drop     <= '0;
    end else begin
      r_outs <= r_outs + OUT_W'(w_cmd_hs) - OUT_W'(itcm_rsp_valid);
      if (flush_req) begin
        r_fetch_pc <= flush_pc;
        r_rsp_pc   <= flush_pc;
        // Everything still outstanding is stale; a response landing now is dropped directly.
        r_drop     <= r_outs - OUT_W'(itcm_rsp_valid);
      end else begin
        if (w_cmd_hs) begin
          r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + PC_STEP;
        end
        if (w_drop_rsp) begin
          r_drop <= r_drop - OUT_W'(1);
        end
      end
    end
  end

  // FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (flush_req) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // FIFO storage, no reset needed: reads are qualified by r_count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= itcm_rsp_rdata;
      r_mem_pc[r_wptr]    <= r_rsp_pc;
    end
  end

`ifdef IFU_PFB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_drop  <= '0;
    end else begin
      if (w_run && o_ready && !w_o_valid && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_drop_rsp && (r_perf_drop != '1)) begin
        r_perf_drop <= r_perf_drop + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_drop_cnt  = r_perf_drop;
`endif

  assign itcm_cmd_valid = w_cmd_valid;
  assign itcm_cmd_addr  = r_fetch_pc[ADDR_W-1:0];
  assign itcm_rsp_ready = 1'b1;
  assign o_valid        = w_o_valid;
  assign o_instr        = r_mem_instr[r_rptr];
  assign o_pc           = r_mem_pc[r_rptr];
  assign flush_ack      = flush_req;
  assign occupancy      = r_count;
  assign o_dbg_state    = logic'(r_state);

endmodule

// File: doc/ifu_prefetch_buf.md
Name: ifu_prefetch_buf

Overview:
Parametrised instruction prefetch buffer that sits between the IFU fetch stage and the ITCM ICB port. Replaces the single-request fetch path with a sequential prefetcher. It keeps up to MAX_OUTS ITCM reads in flight and buffers returned instructions, tagged with their PCs, in a DEPTH-entry FIFO toward the IR stage. A pipeline flush redirects the fetch PC and squashes stale in-flight responses.

Parameters:
PC_W, 32, PC width (matches PC_SIZE)
ADDR_W, 16, ITCM byte-address width (matches ITCM_ADDR_WIDTH)
DW, 32, ITCM data / instruction width; PC step = DW/8
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
MAX_OUTS, 2, maximum outstanding ITCM commands (1..DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc_rtvec  in  PC_W  reset vector, sampled while rst=1
itcm_cmd_valid  out  1  fetch command valid
itcm_cmd_ready  in  1  ITCM accepts command
itcm_cmd_addr  out  ADDR_W  fetch byte address = fetch_pc[ADDR_W-1:0]
itcm_rsp_valid  in  1  read data valid; in order, one per accepted command
itcm_rsp_ready  out  1  always 1
itcm_rsp_rdata  in  DW  read data
o_valid  out  1  FIFO head valid
o_ready  in  1  IR stage accepts head
o_instr  out  DW  head instruction
o_pc  out  PC_W  head PC
flush_req  in  1  redirect request
flush_pc  in  PC_W  redirect target (already op1+op2 summed upstream)
flush_ack  out  1  = flush_req (accepted same cycle, always)
occupancy  out  clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Reset (rst=1): FSM = BOOT. fetch_pc and rsp_pc are loaded with pc_rtvec. FIFO count, outstanding and drop_cnt are cleared. Outputs: itcm_cmd_valid=0, o_valid=0, occupancy=0, flush_ack=flush_req. Reset asserted mid-operation discards everything; later ITCM responses belonging to pre-reset commands are the ITCM's responsibility (the ITCM is reset by the same rst).
- FSM: BOOT -> RUN unconditionally on the first cycle after rst deasserts; itcm_cmd_valid=0 in BOOT. RUN is the only other state.
- Issue rule: itcm_cmd_valid = RUN & !flush_req & (outstanding < MAX_OUTS) & (count + outstanding < DEPTH). This bound makes FIFO overflow impossible.
- On cmd handshake: fetch_pc += DW/8 (wraps modulo 2^PC_W); outstanding++.
- On rsp_valid: outstanding--. If drop_cnt != 0, the data is discarded and drop_cnt--. Otherwise push {rsp_pc, rdata} and rsp_pc += DW/8.
- Simultaneous cmd handshake and rsp in one cycle: outstanding is unchanged.
- Output: o_valid = (count != 0) & !flush_req. o_instr and o_pc come from the head entry. Pop on o_valid & o_ready.
- Simultaneous push and pop leaves count unchanged. Push into an empty FIFO is visible at o_valid the next cycle (no bypass), so minimum fetch-to-IR latency = 2 cycles after cmd handshake with a 1-cycle ITCM.
- Flush (flush_req=1), all in the same cycle:
  - FIFO cleared and no pop.
  - fetch_pc <= flush_pc; rsp_pc <= flush_pc.
  - drop_cnt <= outstanding - (itcm_rsp_valid ? 1 : 0). A response arriving in the flush cycle is discarded, and no command issues in the flush cycle.
  - New commands may issue while drop_cnt != 0; responses stay ordered, so the counter alone separates stale from fresh.
- Back-to-back flushes: each flush recomputes drop_cnt from the current outstanding; the last target wins.
- Counter widths: outstanding and drop_cnt are clog2(MAX_OUTS+1) bits; count is clog2(DEPTH+1) bits. The FIFO pointers are clog2(DEPTH) bits and wrap naturally.

Optional Feature:
IFU_PFB_PERF_EN
- Defined: adds output perf_stall_cnt (32 bits) and output perf_drop_cnt (32 bits).
  - perf_stall_cnt increments each RUN cycle with o_ready=1 & o_valid=0.
  - perf_drop_cnt increments per discarded response.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with pc_rtvec=0x8000_0000, ITCM always ready with 1-cycle response, o_ready=1 -> cmd addresses 0x0000, 0x0004, 0x0008...; first o_valid has o_pc=0x8000_0000; sustained o_valid=1 every cycle after fill.
2. o_ready=0 for 20 cycles -> occupancy reaches 4 and stays; itcm_cmd_valid=0 once count+outstanding=4; no entry lost or duplicated after o_ready=1 (PCs contiguous).
3. Two commands outstanding with ITCM latency 3, then flush_req with flush_pc=0x8000_0100 -> flush_ack=1 that cycle, o_valid=0; the next two responses are dropped; the first o_pc after the flush is 0x8000_0100 with the matching rdata.
4. Flush in the same cycle as rsp_valid and o_ready=1 -> that response is dropped, drop_cnt=outstanding-1, no pop, no cmd issued that cycle.
5. Two flushes on consecutive cycles (targets 0x200, 0x300) -> only PCs from 0x300 onward appear; the total number of dropped responses equals the commands issued before the second flush.
6. rst asserted mid-stream with 3 entries buffered -> next cycle o_valid=0, occupancy=0; fetch restarts at the new pc_rtvec after BOOT.
